// File: rtl/serial_subtractor_8.sv
// serial_subtractor_8: bit-serial 8-bit subtractor, d = x - y - bin.
// One full-subtractor cell processes one bit per clock, LSB first, and the
// per-bit borrow chain is exposed on b[7:0].
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output ovf.
//
// Handshake: start is sampled only while ready (IDLE or DONE); a sampled
// start captures x, y and bin on that edge. busy is high for the eight RUN
// cycles; done is a one-cycle pulse during which d, b and bout are valid.
// start seen during RUN is dropped, never queued.
module serial_subtractor_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] d,
  output logic [7:0] b,
  output logic       bout,
`ifdef SUB_OVF_EN
  output logic       ovf,
`endif
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [7:0] xr;
  logic [7:0] yr;
  logic       br;
  logic       accept;
  logic       p;
  logic       xi;
  logic       yi;
  logic       di;
  logic       bi;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign bout      = b[7];
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: eight RUN cycles per operation, restart directly from DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Full-subtractor cell for the current bit; the incoming borrow is the
  // captured borrow-in for bit 0, otherwise the borrow just written below it.
  always_comb begin
    p  = (idx == 3'd0) ? br : b[idx - 3'd1];
    xi = xr[idx];
    yi = yr[idx];
    di = xi ^ yi ^ p;
    bi = (~xi & yi) | (~(xi ^ yi) & p);
  end

  // Operand capture and one result bit per RUN cycle; results hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 3'd0;
      xr  <= 8'd0;
      yr  <= 8'd0;
      br  <= 1'b0;
      d   <= 8'd0;
      b   <= 8'd0;
`ifdef SUB_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (accept) begin
      idx <= 3'd0;
      xr  <= x;
      yr  <= y;
      br  <= bin;
      d   <= 8'd0;
      b   <= 8'd0;
`ifdef SUB_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == RUN) begin
      d[idx] <= di;
      b[idx] <= bi;
      idx    <= idx + 3'd1;
`ifdef SUB_OVF_EN
      if (idx == 3'd7) ovf <= (xr[7] ^ yr[7]) & (xr[7] ^ di);
`endif
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8.sv
// tb_serial_subtractor_8: scoreboard bench for serial_subtractor_8.
// Build with +define+SUB_OVF_EN to also check the overflow output.
module tb_serial_subtractor_8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic [7:0] b;
  logic       bout;
  logic       ovf;
  logic [1:0] dbg_state;

  // Expected result packed as {ovf, bout, b, d}.
  logic [17:0] exp_q[$];

  int n_checks;
  int n_pass;

  serial_subtractor_8 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .d         (d),
    .b         (b),
    .bout      (bout),
`ifdef SUB_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

`ifndef SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 9-bit difference; borrow out of bit j is set exactly when the
  // low j+1 bits of x are smaller than the low j+1 bits of y plus bin.
  function automatic logic [17:0] model(input logic [7:0] mx, input logic [7:0] my,
                                        input logic mb);
    logic [8:0] r;
    logic [7:0] bv;
    logic [9:0] m;
    logic       ov;
    r = {1'b0, mx} - {1'b0, my} - {8'd0, mb};
    for (int j = 0; j < 8; j++) begin
      m     = (10'd1 << (j + 1)) - 10'd1;
      bv[j] = (({2'b0, mx} & m) < (({2'b0, my} & m) + {9'd0, mb}));
    end
    ov = (mx[7] != my[7]) && (r[7] != mx[7]);
`ifndef SUB_OVF_EN
    ov = 1'b0;
`endif
    return {ov, r[8], bv, r[7:0]};
  endfunction

  // Waits up to 20 cycles for done; lat is the number of negedges waited, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Pops the oldest expected result and compares it with the outputs now visible.
  task automatic check_result(input string name);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty at done", name);
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e[7:0]) $display("FAIL %s d: got %h expected %h", name, d, e[7:0]);
    else n_pass++;
    n_checks++;
    if (b !== e[15:8]) $display("FAIL %s b: got %h expected %h", name, b, e[15:8]);
    else n_pass++;
    n_checks++;
    if (bout !== e[16]) $display("FAIL %s bout: got %b expected %b", name, bout, e[16]);
    else n_pass++;
`ifdef SUB_OVF_EN
    n_checks++;
    if (ovf !== e[17]) $display("FAIL %s ovf: got %b expected %b", name, ovf, e[17]);
    else n_pass++;
`endif
  endtask

  // Runs one isolated operation with a single-cycle start pulse.
  task automatic run_op(input logic [7:0] vx, input logic [7:0] vy, input logic vb,
                        input string name);
    int lat;
    @(negedge clk);
    start = 1'b1; x = vx; y = vy; bin = vb;
    exp_q.push_back(model(vx, vy, vb));
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255)); bin = 1'($urandom_range(0, 1));
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy: got %b expected 1", name, busy);
    else n_pass++;
    wait_done(lat);
    n_checks++;
    if (lat + 1 !== 9) $display("FAIL %s latency: got %0d expected 9", name, lat + 1);
    else n_pass++;
    if (lat > 0) check_result(name);
    else void'(exp_q.pop_front());
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after-done: got done=%b busy=%b expected 0 0", name, done, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x = 8'd0; y = 8'd0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, bout, ovf} !== 4'b0000)
      $display("FAIL reset flags: got busy=%b done=%b bout=%b ovf=%b expected 0", busy, done, bout, ovf);
    else n_pass++;
    n_checks++;
    if ({d, b} !== 16'h0000) $display("FAIL reset data: got d=%h b=%h expected 00 00", d, b);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_op(8'h05, 8'h03, 1'b0, "sub_05_03");
    run_op(8'h00, 8'h01, 1'b0, "sub_00_01");
    run_op(8'h10, 8'h0F, 1'b1, "sub_10_0F_b");
    run_op(8'h80, 8'h01, 1'b0, "sub_80_01");
    run_op(8'h7F, 8'hFF, 1'b0, "sub_7F_FF");
    run_op(8'hFF, 8'hFF, 1'b1, "sub_FF_FF_b");
    for (int i = 0; i < 6; i++)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), "sub_rand");
  endtask

  task automatic test_back_to_back();
    int lat;
    int c;
    @(negedge clk);
    start = 1'b1; x = 8'h05; y = 8'h03; bin = 1'b0;
    exp_q.push_back(model(8'h05, 8'h03, 1'b0));
    @(negedge clk);
    // start stays high; new operands wait for the DONE cycle
    x = 8'h00; y = 8'h01;
    exp_q.push_back(model(8'h00, 8'h01, 1'b0));
    wait_done(lat);
    n_checks++;
    if (lat + 1 !== 9) $display("FAIL b2b first latency: got %0d expected 9", lat + 1);
    else n_pass++;
    check_result("b2b_first");
    c = 1;
    @(negedge clk);
    start = 1'b0; x = 8'hAA; y = 8'h55;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b restart busy: got %b expected 1", busy);
    else n_pass++;
    c++;
    @(negedge clk);
    start = 1'b1; bin = 1'b1;   // pulse mid-RUN must be ignored
    c++;
    @(negedge clk);
    start = 1'b0; bin = 1'b0;
    wait_done(lat);
    c += lat;
    n_checks++;
    if (lat < 0 || c !== 9) $display("FAIL b2b done spacing: got %0d expected 9", c);
    else n_pass++;
    check_result("b2b_second");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b no-queue: got busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat;
    @(negedge clk);
    start = 1'b1; x = 8'h3C; y = 8'hA5; bin = 1'b1;
    @(negedge clk);   // RUN cycle 1
    start = 1'b0;
    repeat (3) @(negedge clk);   // RUN cycle 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, bout} !== 3'b000 || {d, b} !== 16'h0000)
      $display("FAIL abort outputs: got busy=%b done=%b bout=%b d=%h b=%h expected all 0",
               busy, done, bout, d, b);
    else n_pass++;
    wait_done(lat);
    n_checks++;
    if (lat !== -1) $display("FAIL abort no-done: got done after %0d cycles expected none", lat);
    else n_pass++;
    run_op(8'h5A, 8'h3B, 1'b0, "after_abort");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_abort();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard leftover: got %0d expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
